// File: rtl/matrix_exec_master.sv
`default_nettype none
// ============================================================================
// Module   : matrix_exec_master
// Brief    : Command-driven bus master that writes two operands to a matrix
//            ALU, triggers execution, reads the result back and returns it on
//            a valid/ready response channel. Optional macro
//            MXM_TRANSPOSE_SKIP_EN skips the second operand write for op 3.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_exec_master #(
    parameter logic [3:0] ALU_BASE   = 4'h2,
    parameter int         RD_LATENCY = 1
) (
    input  logic         Clk,
    input  logic         nReset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic [255:0] cmd_src1,
    input  logic [255:0] cmd_src2,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [255:0] rsp_data,
    output logic [3:0]   rsp_op,
    output logic         rsp_err,
    output logic         busy,
    output logic [15:0]  address,
    output logic         nWrite,
    output logic         nRead,
    output logic [255:0] ExeDataOut,
    input  logic [255:0] MatrixDataOut
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_WR1  = 3'd1;
    localparam logic [2:0] c_WR2  = 3'd2;
    localparam logic [2:0] c_EXEC = 3'd3;
    localparam logic [2:0] c_RD   = 3'd4;
    localparam logic [2:0] c_CAPT = 3'd5;
    localparam logic [2:0] c_RSP  = 3'd6;

    localparam logic [2:0] c_LAT_LAST = 3'(RD_LATENCY - 1);
    localparam logic [3:0] c_OP_MAX   = 4'd5;
    localparam logic [3:0] c_OP_TRANS = 4'd3;

    logic [2:0]   r_state;
    logic [3:0]   r_op;
    logic [255:0] r_src1;
    logic [255:0] r_src2;
    logic [2:0]   r_cnt;
    logic [255:0] r_rsp_data;
    logic         r_rsp_err;
    logic         w_skip_wr2;

`ifdef MXM_TRANSPOSE_SKIP_EN
    assign w_skip_wr2 = (r_op == c_OP_TRANS);
`else
    assign w_skip_wr2 = 1'b0;
`endif

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state    <= c_IDLE;
            r_op       <= 4'h0;
            r_src1     <= '0;
            r_src2     <= '0;
            r_cnt      <= 3'd0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (cmd_valid) begin
                        r_op   <= cmd_op;
                        r_src1 <= cmd_src1;
                        r_src2 <= cmd_src2;
                        if (cmd_op > c_OP_MAX) begin
                            // Illegal opcode: answer immediately, never touch the bus
                            r_rsp_err  <= 1'b1;
                            r_rsp_data <= '0;
                            r_state    <= c_RSP;
                        end else begin
                            r_rsp_err <= 1'b0;
                            r_state   <= c_WR1;
                        end
                    end
                end
                c_WR1:  r_state <= w_skip_wr2 ? c_EXEC : c_WR2;
                c_WR2:  r_state <= c_EXEC;
                c_EXEC: r_state <= c_RD;
                c_RD: begin
                    r_cnt   <= 3'd0;
                    r_state <= c_CAPT;
                end
                c_CAPT: begin
                    if (r_cnt == c_LAT_LAST) begin
                        r_rsp_data <= MatrixDataOut;
                        r_state    <= c_RSP;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                c_RSP: begin
                    if (rsp_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Bus outputs decode straight from state so reset idles the bus at once
    always_comb begin
        address    = 16'h0000;
        nWrite     = 1'b1;
        nRead      = 1'b1;
        ExeDataOut = '0;
        case (r_state)
            c_WR1: begin
                address    = {ALU_BASE, 4'h0, r_op, 4'h0};
                nWrite     = 1'b0;
                ExeDataOut = r_src1;
            end
            c_WR2: begin
                address    = {ALU_BASE, 4'h0, r_op, 4'h1};
                nWrite     = 1'b0;
                ExeDataOut = r_src2;
            end
            c_EXEC: address = {ALU_BASE, 4'h0, r_op, 4'h3};
            c_RD: begin
                address = {ALU_BASE, 4'h0, r_op, 4'h2};
                nRead   = 1'b0;
            end
            default: ;
        endcase
    end

    assign cmd_ready = (r_state == c_IDLE);
    assign busy      = (r_state != c_IDLE);
    assign rsp_valid = (r_state == c_RSP);
    assign rsp_data  = r_rsp_data;
    assign rsp_op    = r_op;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_matrix_exec_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_exec_master
// Brief    : Self-checking bench with a behavioural matrix ALU bus slave and a
//            transaction-level reference model for matrix_exec_master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_exec_master;

    localparam logic [3:0] BASE = 4'h2;
    localparam int         RDL  = 1;
`ifdef MXM_TRANSPOSE_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic         Clk = 1'b0;
    logic         nReset = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [3:0]   cmd_op = 4'h0;
    logic [255:0] cmd_src1 = '0;
    logic [255:0] cmd_src2 = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [255:0] rsp_data;
    logic [3:0]   rsp_op;
    logic         rsp_err;
    logic         busy;
    logic [15:0]  address;
    logic         nWrite;
    logic         nRead;
    logic [255:0] ExeDataOut;
    logic [255:0] MatrixDataOut;

    int tests = 0;
    int fails = 0;

    matrix_exec_master #(.ALU_BASE(BASE), .RD_LATENCY(RDL)) dut (
        .Clk(Clk), .nReset(nReset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_op(rsp_op), .rsp_err(rsp_err), .busy(busy),
        .address(address), .nWrite(nWrite), .nRead(nRead),
        .ExeDataOut(ExeDataOut), .MatrixDataOut(MatrixDataOut)
    );

    always #5 Clk = ~Clk;

    // 4x4 matrix of 16-bit elements, element (r,c) at bits [(r*4+c)*16 +: 16]
    function automatic logic [255:0] alu(input logic [3:0] op, input logic [255:0] a, input logic [255:0] b);
        logic [255:0] r;
        logic [15:0]  acc;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 16'h0;
                case (op)
                    4'd0: for (int k = 0; k < 4; k++)
                              acc = acc + a[(i*4+k)*16 +: 16] * b[(k*4+j)*16 +: 16];
                    4'd1: acc = a[(i*4+j)*16 +: 16] + b[(i*4+j)*16 +: 16];
                    4'd2: acc = a[(i*4+j)*16 +: 16] - b[(i*4+j)*16 +: 16];
                    4'd3: acc = a[(j*4+i)*16 +: 16];
                    4'd4: acc = a[(i*4+j)*16 +: 16] * b[15:0];
                    4'd5: acc = a[(i*4+j)*16 +: 16] * b[31:16];
                    default: acc = 16'h0;
                endcase
                r[(i*4+j)*16 +: 16] = acc;
            end
        end
        return r;
    endfunction

    // Behavioural ALU slave: result only valid RDL cycles after the read strobe
    logic [255:0] alu_a = '0, alu_b = '0, alu_res = '0;
    logic [3:0]   alu_op = 4'h0;
    int           rdcnt = 0;
    always @(posedge Clk) begin
        if (!nWrite && address[15:12] == BASE) begin
            if (address[3:0] == 4'h0) begin
                alu_a  <= ExeDataOut;
                alu_op <= address[7:4];
            end
            if (address[3:0] == 4'h1) alu_b <= ExeDataOut;
        end
        if (nWrite && nRead && address[15:12] == BASE && address[3:0] == 4'h3)
            alu_res <= alu(alu_op, alu_a, alu_b);
        if (!nRead) rdcnt <= 1;
        else if (rdcnt == RDL) rdcnt <= 0;
        else if (rdcnt != 0) rdcnt <= rdcnt + 1;
    end
    assign MatrixDataOut = (rdcnt == RDL) ? alu_res : {16{16'hDEAD}};

    // Bus monitor: log every non-idle cycle as {address, nWrite, nRead}
    logic [17:0] bus_q[$];
    int          bus_viol = 0;
    always @(negedge Clk) begin
        if (address != 16'h0000 || !nWrite || !nRead) bus_q.push_back({address, nWrite, nRead});
        if (!nWrite && !nRead) bus_viol++;
    end

    task automatic run_cmd(input logic [3:0] op, input logic [255:0] s1, input logic [255:0] s2,
                           input int hold, input bit pulse);
        logic [17:0]  exp_q[$];
        logic [255:0] exp_data;
        bit           illegal;
        int           exp_edges;
        int           n;
        int           w;
        illegal  = (op > 4'd5);
        exp_data = illegal ? '0 : alu(op, s1, s2);
        // Edges after the accept edge until rsp_valid rises; illegal ops answer on the accept edge itself
        exp_edges = illegal ? 0 : ((SKIP && op == 4'd3) ? 3 + RDL : 4 + RDL);
        if (!illegal) begin
            exp_q.push_back({BASE, 4'h0, op, 4'h0, 1'b0, 1'b1});
            if (!(SKIP && op == 4'd3)) exp_q.push_back({BASE, 4'h0, op, 4'h1, 1'b0, 1'b1});
            exp_q.push_back({BASE, 4'h0, op, 4'h3, 1'b1, 1'b1});
            exp_q.push_back({BASE, 4'h0, op, 4'h2, 1'b1, 1'b0});
        end
        w = 0;
        @(negedge Clk);
        while (!cmd_ready && w < 50) begin
            @(negedge Clk);
            w++;
        end
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL cmd_ready_timeout: cmd_ready=%b required 1", cmd_ready);
            return;
        end
        bus_q.delete();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src1  = s1;
        cmd_src2  = s2;
        rsp_ready = (hold == 0);
        @(posedge Clk);
        #1;
        cmd_valid = 1'b0;
        cmd_src1  = $urandom;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!rsp_valid && n < 30);
        tests++;
        if (rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL rsp_timeout op=%0d: rsp_valid=%b required 1", op, rsp_valid);
            rsp_ready = 1'b0;
            return;
        end
        tests++;
        if (n - 1 !== exp_edges) begin
            fails++;
            $display("FAIL latency op=%0d: got %0d required %0d", op, n - 1, exp_edges);
        end
        tests++;
        if (rsp_data !== exp_data || rsp_op !== op || rsp_err !== illegal) begin
            fails++;
            $display("FAIL response op=%0d: data=%h op=%0d err=%b required data=%h op=%0d err=%b",
                     op, rsp_data, rsp_op, rsp_err, exp_data, op, illegal);
        end
        for (int i = 0; i < hold; i++) begin
            if (pulse && i == 2) begin
                cmd_valid = 1'b1;
                cmd_op    = 4'h1;
                cmd_src1  = {8{$urandom}};
            end
            if (pulse && i == 3) cmd_valid = 1'b0;
            @(negedge Clk);
            tests++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_data || cmd_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold_stable op=%0d cyc=%0d: valid=%b ready=%b data=%h required 1 0 %h",
                         op, i, rsp_valid, cmd_ready, rsp_data, exp_data);
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge Clk);
        #1;
        rsp_ready = 1'b0;
        tests++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL handshake_done op=%0d: busy=%b cmd_ready=%b rsp_valid=%b required 0 1 0",
                     op, busy, cmd_ready, rsp_valid);
        end
        @(negedge Clk);
        tests++;
        if (bus_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL bus_len op=%0d: %0d cycles required %0d", op, bus_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < bus_q.size(); i++) begin
            tests++;
            if (bus_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL bus_cycle op=%0d idx=%0d: addr=%h nW=%b nR=%b required addr=%h nW=%b nR=%b",
                         op, i, bus_q[i][17:2], bus_q[i][1], bus_q[i][0],
                         exp_q[i][17:2], exp_q[i][1], exp_q[i][0]);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
            rsp_data !== '0 || rsp_op !== 4'h0 || address !== 16'h0 || nWrite !== 1'b1 ||
            nRead !== 1'b1 || ExeDataOut !== '0) begin
            fails++;
            $display("FAIL reset_state: ready=%b busy=%b valid=%b err=%b op=%h addr=%h nW=%b nR=%b",
                     cmd_ready, busy, rsp_valid, rsp_err, rsp_op, address, nWrite, nRead);
        end
        repeat (3) @(negedge Clk);
        nReset = 1'b1;
        @(negedge Clk);
        tests++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: busy=%b cmd_ready=%b required 0 1", busy, cmd_ready);
        end
    endtask

    task automatic test_add();
        logic [255:0] want;
        want = {16{16'h0003}};
        run_cmd(4'd1, {16{16'h0001}}, {16{16'h0002}}, 0, 1'b0);
        tests++;
        if (rsp_data !== want) begin
            fails++;
            $display("FAIL add_const: data=%h required %h", rsp_data, want);
        end
    endtask

    task automatic test_sub_bus();
        run_cmd(4'd2, {8{$urandom}}, {8{$urandom}}, 1, 1'b0);
    endtask

    task automatic test_illegal();
        run_cmd(4'h7, {8{$urandom}}, {8{$urandom}}, 2, 1'b0);
        run_cmd(4'hF, {8{$urandom}}, {8{$urandom}}, 0, 1'b0);
    endtask

    task automatic test_transpose();
        run_cmd(4'd3, {8{$urandom}}, {8{$urandom}}, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_cmd(4'd0, {8{$urandom}}, {8{$urandom}}, 10, 1'b1);
        repeat (3) @(negedge Clk);
        tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL ignored_cmd: rsp_valid=%b busy=%b required 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        @(negedge Clk);
        cmd_valid = 1'b1;
        cmd_op    = 4'd1;
        cmd_src1  = {8{$urandom}};
        cmd_src2  = {8{$urandom}};
        @(posedge Clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge Clk);
        #1;
        tests++;
        if (address !== {BASE, 8'h01, 4'h1}) begin
            fails++;
            $display("FAIL wr2_reached: addr=%h required %h", address, {BASE, 8'h01, 4'h1});
        end
        nReset = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || address !== 16'h0 || nWrite !== 1'b1 || nRead !== 1'b1 ||
            cmd_ready !== 1'b1 || ExeDataOut !== '0 || rsp_data !== '0) begin
            fails++;
            $display("FAIL async_reset: busy=%b addr=%h nW=%b nR=%b ready=%b required 0 0000 1 1 1",
                     busy, address, nWrite, nRead, cmd_ready);
        end
        seen = 0;
        repeat (3) begin
            @(negedge Clk);
            if (rsp_valid) seen++;
        end
        nReset = 1'b1;
        repeat (8) begin
            @(negedge Clk);
            if (rsp_valid) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL aborted_rsp: rsp_valid seen %0d cycles required 0", seen);
        end
        run_cmd(4'd1, {8{$urandom}}, {8{$urandom}}, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++)
            run_cmd(4'($urandom_range(0, 7)), {8{$urandom}}, {8{$urandom}}, $urandom_range(0, 3), 1'b0);
    endtask

    task automatic test_bus_rules();
        tests++;
        if (bus_viol != 0) begin
            fails++;
            $display("FAIL strobe_overlap: %0d cycles with nRead=nWrite=0 required 0", bus_viol);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_bus();
        test_illegal();
        test_transpose();
        test_backpressure();
        test_reset_midflight();
        test_random();
        test_bus_rules();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matrix_exec_master.md
MATRIX_EXEC_MASTER -- requirements
Module: matrix_exec_master

Interface
REQ-001 SHALL have parameter ALU_BASE, default 4'h2, meaning the matrix ALU select placed on address[15:12].
REQ-002 SHALL have parameter RD_LATENCY, default 1, legal range 1-4, meaning cycles from the read-strobe cycle to valid MatrixDataOut.
REQ-003 SHALL have port Clk  in  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port nReset  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_op in 4 (0 MUL, 1 ADD, 2 SUB, 3 TRANSPOSE, 4 SCALE, 5 SCALEIMM), cmd_src1 in 256, cmd_src2 in 256.
REQ-006 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_data out 256, rsp_op out 4, rsp_err out 1 (illegal opcode).
REQ-007 SHALL have port busy  out  1  high in every state except IDLE.
REQ-008 SHALL have ALU bus ports: address out 16, nWrite out 1, nRead out 1, ExeDataOut out 256, MatrixDataOut in 256.

Function
REQ-009 SHALL implement the FSM states IDLE, WR1, WR2, EXEC, RD, CAPT and RSP, advancing one state per clock unless stated otherwise.
REQ-010 In IDLE, SHALL drive cmd_ready=1, accept on cmd_valid&cmd_ready, register op/src1/src2, and go to WR1; cmd_ready SHALL be 0 in all other states.
REQ-011 If the accepted op > 5, SHALL skip to RSP with rsp_err=1, rsp_data=0, and issue no bus cycle.
REQ-012 WR1: address={ALU_BASE,4'h0,op,4'h0}, nWrite=0, nRead=1, ExeDataOut=src1, one cycle.
REQ-013 WR2: same as WR1 but address[3:0]=4'h1 and ExeDataOut=src2, one cycle.
REQ-014 EXEC: address[3:0]=4'h3, nWrite=1, nRead=1, one cycle.
REQ-015 RD: address[3:0]=4'h2, nRead=0, nWrite=1, one cycle.
REQ-016 CAPT: bus idle; count RD_LATENCY cycles and load MatrixDataOut into rsp_data on the edge ending the last one, then go to RSP.
REQ-017 Bus idle SHALL mean address=16'h0000, nRead=1, nWrite=1, ExeDataOut=0; it SHALL apply in IDLE, CAPT and RSP.
REQ-018 nRead and nWrite SHALL never both be 0 in the same cycle.
REQ-019 RSP: rsp_valid=1 with rsp_data/rsp_op/rsp_err stable until rsp_ready=1; the handshake completes on that edge and the FSM goes to IDLE.
REQ-020 rsp_ready high on the first RSP cycle SHALL complete in one cycle; rsp_ready outside RSP SHALL be ignored.
REQ-021 Latency from the accept edge to rsp_valid high SHALL be 4+RD_LATENCY cycles for legal ops (REQ-024 exception) and 1 cycle for illegal ops.
REQ-022 cmd_valid while busy SHALL be ignored and its command not captured.

Reset
REQ-023 nReset low SHALL immediately, including mid-transaction, force IDLE, bus idle, cmd_ready=1, rsp_valid=0, rsp_err=0, busy=0, rsp_data=0 and rsp_op=0; the aborted command SHALL produce no response.

Configuration
REQ-024 With macro MXM_TRANSPOSE_SKIP_EN defined, op 3 SHALL go WR1->EXEC, skipping WR2, for a latency of 3+RD_LATENCY; without the macro, every legal op SHALL pass through WR2.

Verification
REQ-025 ADD, src1 all 16'h0001, src2 all 16'h0002, behavioural ALU model -> rsp_valid 5 cycles after accept, rsp_data all 16'h0003, rsp_err=0.
REQ-026 Bus sequence for op 2 -> addresses 16'h2020, 16'h2021, 16'h2023, 16'h2022 on consecutive cycles, then 16'h0000, with nRead=0 only on 16'h2022.
REQ-027 cmd_op=4'h7 -> no address with [15:12]=2, rsp_valid next cycle, rsp_err=1, rsp_data=0.
REQ-028 rsp_ready held low 10 cycles, new cmd_valid pulsed -> rsp_data stable, cmd_ready=0, second command ignored; completes after rsp_ready.
REQ-029 nReset low during WR2 -> same-cycle bus idle and busy=0; no rsp_valid; the next command completes normally.
REQ-030 TRANSPOSE with MXM_TRANSPOSE_SKIP_EN defined -> no 16'h2031 cycle, latency 4; without the macro -> 16'h2031 present, latency 5.
